// File: rtl/uart_cmd_seq.sv
// uart_cmd_seq: assembles two received UART bytes into a 16-bit command.
// Ports: clk, rst (sync, active-high); rx_rdy/rx_data in, clr_rx_rdy out to
// the receiver; cmd/cmd_rdy/overrun/timeout_err out, clr_cmd_rdy in from the
// command consumer. TIMEOUT is the inter-byte timeout in clk cycles.
module uart_cmd_seq #(
    parameter int unsigned TIMEOUT = 60000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        rx_rdy,
    input  logic [7:0]  rx_data,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic [15:0] cmd,
    output logic        cmd_rdy,
    output logic        overrun,
    output logic        timeout_err
);

    typedef enum logic [1:0] {
        IDLE,
        CLR_HI,
        WAIT_LO,
        CLR_LO
    } state_t;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

    state_t      state_q, state_d;
    logic [7:0]  hi_q, hi_d;
    logic [15:0] cnt_q, cnt_d, cnt_inc;
    logic [15:0] cmd_q, cmd_d;
    logic        cmd_rdy_q, cmd_rdy_d;
    logic        overrun_q, overrun_d;
    logic        clr_q, clr_d;
    logic        tout_q, tout_d;

    // Saturating increment.
    assign cnt_inc = (cnt_q == 16'hFFFF) ? cnt_q : cnt_q + 16'd1;

    always_comb begin
        state_d   = state_q;
        hi_d      = hi_q;
        cnt_d     = cnt_q;
        cmd_d     = cmd_q;
        cmd_rdy_d = cmd_rdy_q & ~clr_cmd_rdy;
        overrun_d = overrun_q & ~clr_cmd_rdy;
        clr_d     = 1'b0;
        tout_d    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (rx_rdy) begin
                    hi_d    = rx_data;
                    cnt_d   = 16'd0;
                    clr_d   = 1'b1;
                    state_d = CLR_HI;
                end
            end
            CLR_HI: begin
                cnt_d   = cnt_inc;
                state_d = WAIT_LO;
            end
            WAIT_LO: begin
                cnt_d = cnt_inc;
                // A byte arriving on the expiry cycle beats the timeout.
                if (rx_rdy) begin
                    cmd_d     = {hi_q, rx_data};
                    cmd_rdy_d = 1'b1;
                    if (cmd_rdy_q && !clr_cmd_rdy) begin
                        overrun_d = 1'b1;
                    end
                    clr_d   = 1'b1;
                    state_d = CLR_LO;
                end else if (cnt_q == CNT_LAST) begin
                    tout_d  = 1'b1;
                    hi_d    = 8'h00;
                    state_d = IDLE;
                end
            end
            CLR_LO: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= IDLE;
            hi_q      <= 8'h00;
            cnt_q     <= 16'd0;
            cmd_q     <= 16'h0000;
            cmd_rdy_q <= 1'b0;
            overrun_q <= 1'b0;
            clr_q     <= 1'b0;
            tout_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            hi_q      <= hi_d;
            cnt_q     <= cnt_d;
            cmd_q     <= cmd_d;
            cmd_rdy_q <= cmd_rdy_d;
            overrun_q <= overrun_d;
            clr_q     <= clr_d;
            tout_q    <= tout_d;
        end
    end

    assign clr_rx_rdy  = clr_q;
    assign cmd         = cmd_q;
    assign cmd_rdy     = cmd_rdy_q;
    assign overrun     = overrun_q;
    assign timeout_err = tout_q;

endmodule

// File: tb/tb_uart_cmd_seq.sv
// tb_uart_cmd_seq: directed self-checking bench for uart_cmd_seq.
// Drives a default-TIMEOUT instance and a TIMEOUT=100 instance in parallel.
module tb_uart_cmd_seq;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rx_rdy = 1'b0;
    logic [7:0]  rx_data = 8'h00;
    logic        clr_cmd_rdy = 1'b0;

    logic        clr_a, rdy_a, ovr_a, tout_a;
    logic [15:0] cmd_a;
    logic        clr_b, rdy_b, ovr_b, tout_b;
    logic [15:0] cmd_b;

    int n_cmp = 0;
    int n_err = 0;
    int np_a  = 0;
    int nt_a  = 0;

    always #5 clk = ~clk;

    uart_cmd_seq u_dut (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_a), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd_a),
        .cmd_rdy(rdy_a), .overrun(ovr_a), .timeout_err(tout_a)
    );

    uart_cmd_seq #(.TIMEOUT(100)) u_dut100 (
        .clk(clk), .rst(rst), .rx_rdy(rx_rdy), .rx_data(rx_data),
        .clr_rx_rdy(clr_b), .clr_cmd_rdy(clr_cmd_rdy), .cmd(cmd_b),
        .cmd_rdy(rdy_b), .overrun(ovr_b), .timeout_err(tout_b)
    );

    always @(posedge clk) begin
        if (rst) begin
            np_a <= 0;
            nt_a <= 0;
        end else begin
            if (clr_a) np_a <= np_a + 1;
            if (tout_a) nt_a <= nt_a + 1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_clr();
        bit seen;
        seen = 1'b0;
        for (int i = 0; i < 8 && !seen; i++) begin
            @(negedge clk);
            if (clr_a | clr_b) seen = 1'b1;
        end
        rx_rdy = 1'b0;
        chk("clr_seen", 32'(seen), 32'd1);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = b;
        wait_clr();
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        int early;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 32'(cmd_a), 32'h0);
        chk("rst_rdy", 32'(rdy_a), 32'h0);
        chk("rst_ovr", 32'(ovr_a), 32'h0);
        chk("rst_tout", 32'(tout_a), 32'h0);
        chk("rst_clr", 32'(clr_a), 32'h0);
        rst = 1'b0;

        // Basic command with a 1000-cycle gap.
        send_byte(8'hA5);
        chk("hi_hidden", 32'(cmd_a), 32'h0);
        repeat (1000) @(negedge clk);
        send_byte(8'h3C);
        chk("s1_cmd", 32'(cmd_a), 32'hA53C);
        chk("s1_rdy", 32'(rdy_a), 32'h1);
        chk("s1_ovr", 32'(ovr_a), 32'h0);
        repeat (2) @(negedge clk);
        chk("s1_pulses", 32'(np_a), 32'd2);
        chk("s1_no_tout", 32'(nt_a), 32'd0);

        // Timeout on the TIMEOUT=100 instance.
        do_reset();
        send_byte(8'hBE);
        send_byte(8'hEF);
        chk("s2_pre_cmd", 32'(cmd_b), 32'hBEEF);
        send_byte(8'h11);
        early = 0;
        for (int i = 1; i < 100; i++) begin
            @(negedge clk);
            if (tout_b) early++;
        end
        chk("s2_tout_early", 32'(early), 32'd0);
        @(negedge clk);
        chk("s2_tout_100", 32'(tout_b), 32'h1);
        chk("s2_cmd", 32'(cmd_b), 32'hBEEF);
        chk("s2_rdy", 32'(rdy_b), 32'h1);
        @(negedge clk);
        chk("s2_tout_1cyc", 32'(tout_b), 32'h0);

        // Byte arrives exactly on the expiry cycle.
        do_reset();
        send_byte(8'h77);
        for (int i = 1; i < 100; i++) @(negedge clk);
        rx_rdy  = 1'b1;
        rx_data = 8'h22;
        @(negedge clk);
        rx_rdy = 1'b0;
        chk("s3_cmd", 32'(cmd_b), 32'h7722);
        chk("s3_rdy", 32'(rdy_b), 32'h1);
        chk("s3_clr", 32'(clr_b), 32'h1);
        chk("s3_tout", 32'(tout_b), 32'h0);
        @(negedge clk);
        chk("s3_tout2", 32'(tout_b), 32'h0);

        // Overrun then acknowledge.
        do_reset();
        send_byte(8'h12);
        send_byte(8'h34);
        chk("s4_cmd1", 32'(cmd_a), 32'h1234);
        chk("s4_ovr1", 32'(ovr_a), 32'h0);
        send_byte(8'h56);
        send_byte(8'h78);
        chk("s4_cmd2", 32'(cmd_a), 32'h5678);
        chk("s4_rdy2", 32'(rdy_a), 32'h1);
        chk("s4_ovr2", 32'(ovr_a), 32'h1);
        @(negedge clk);
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        clr_cmd_rdy = 1'b0;
        chk("s4_rdy_clr", 32'(rdy_a), 32'h0);
        chk("s4_ovr_clr", 32'(ovr_a), 32'h0);

        // Acknowledge coincident with second-byte capture: set wins.
        send_byte(8'h9A);
        send_byte(8'hBC);
        send_byte(8'hDE);
        @(negedge clk);
        rx_rdy = 1'b1;
        rx_data = 8'hF0;
        clr_cmd_rdy = 1'b1;
        @(negedge clk);
        rx_rdy = 1'b0;
        clr_cmd_rdy = 1'b0;
        chk("s5_cmd", 32'(cmd_a), 32'hDEF0);
        chk("s5_rdy", 32'(rdy_a), 32'h1);
        chk("s5_ovr", 32'(ovr_a), 32'h0);

        // Reset in WAIT_LO with rx_rdy held across reset.
        repeat (2) @(negedge clk);
        send_byte(8'hFF);
        @(negedge clk);
        rst = 1'b1;
        rx_rdy = 1'b1;
        rx_data = 8'h01;
        @(negedge clk);
        chk("s6_cmd", 32'(cmd_a), 32'h0);
        chk("s6_rdy", 32'(rdy_a), 32'h0);
        chk("s6_ovr", 32'(ovr_a), 32'h0);
        chk("s6_tout", 32'(tout_a), 32'h0);
        @(negedge clk);
        chk("s6_clr", 32'(clr_a), 32'h0);
        rst = 1'b0;
        wait_clr();
        chk("s6_hi_hidden", 32'(cmd_a), 32'h0);
        send_byte(8'h02);
        chk("s6_cmd2", 32'(cmd_a), 32'h0102);
        chk("s6_rdy2", 32'(rdy_a), 32'h1);
        chk("s6_no_tout", 32'(nt_a), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
